// File: rtl/expr_div_pkg.sv
// expr_div_pkg: shared states, operand/result pair types and default widths for the divider sequencer.
package expr_div_pkg;

    localparam int DW  = 16;
    localparam int DAW = 3;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, STORE, FIN} state_t;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } operand_t;

    typedef struct packed {
        logic [DW-1:0] quot;
        logic [DW-1:0] rem;
    } result_t;

endpackage

// File: rtl/expr_div_sequencer_if.sv
// expr_div_sequencer_if: load/calc handshake between the sequencer and the sequential divider.
interface expr_div_sequencer_if
    import expr_div_pkg::*;
#(
    parameter int W = DW
);

    logic [W-1:0] div_x;
    logic [W-1:0] div_y;
    logic         div_load;
    logic [W-1:0] div_quot;
    logic [W-1:0] div_rem;

    modport master (output div_x, div_y, div_load, input div_quot, div_rem);
    modport slave  (input div_x, div_y, div_load, output div_quot, div_rem);

endinterface

// File: rtl/expr_pair_ram.sv
// expr_pair_ram: DEPTH x DW RAM, synchronous write, registered read (old data on same-cycle write).
module expr_pair_ram #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    // Storage is never cleared; only the write port touches it
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    // Read register clears on reset so downstream outputs start at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd <= '0;
        else
            rd <= mem[ra];
    end

endmodule

// File: rtl/expr_div_sequencer.sv
// expr_div_sequencer: issues stored (x, y) pairs to the sequential divider and collects quot/rem.
// Optional DIVZERO_CHECK_EN: zero divisors bypass the divider and are flagged in dz_flags.
module expr_div_sequencer
    import expr_div_pkg::*;
#(
    parameter int W           = DW,
    parameter int AW          = DAW,
    parameter int LOAD_CYCLES = 10,
    parameter int CALC_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [W-1:0]      wr_x,
    input  logic [W-1:0]      wr_y,
    input  logic              run,
    input  logic [AW:0]       count,
    output logic              busy,
    output logic              done,
    input  logic [AW-1:0]     rd_addr,
    output logic [W-1:0]      rd_quot,
    output logic [W-1:0]      rd_rem,
`ifdef DIVZERO_CHECK_EN
    output logic [2**AW-1:0]  dz_flags,
`endif
    expr_div_sequencer_if.master div
);

    localparam int DEPTH = 2**AW;
    localparam int CMAX  = LOAD_CYCLES > CALC_CYCLES ? LOAD_CYCLES : CALC_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    state_t          state, state_n;
    logic [AW-1:0]   idx, idx_n;
    logic [AW:0]     cnt, count_sat;
    logic [CW-1:0]   cyc;
    logic [2*W-1:0]  op_rd, res_rd, res_wd;
    logic [W-1:0]    op_x, op_y;
    logic            accept, last, dz;

    assign op_x      = op_rd[2*W-1:W];
    assign op_y      = op_rd[W-1:0];
    assign accept    = state == IDLE && run;
    assign count_sat = count > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : count;
    assign last      = {1'b0, idx} == cnt - (AW+1)'(1);

`ifdef DIVZERO_CHECK_EN
    assign dz = op_y == '0;
`else
    assign dz = 1'b0;
`endif

    assign res_wd            = dz ? {{W{1'b1}}, op_x} : {div.div_quot, div.div_rem};
    assign {rd_quot, rd_rem} = res_rd;
    assign done              = state == FIN;
    assign div.div_load      = state != CALC;
    assign div.div_x         = op_x;
    assign div.div_y         = op_y;

    // Operand read address follows idx_n so mem[idx] is already on div_x/div_y in the first LOAD cycle
    expr_pair_ram #(.AW(AW), .DW(2*W)) u_op_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && state == IDLE),
        .wa    (wr_addr),
        .wd    ({wr_x, wr_y}),
        .ra    (idx_n),
        .rd    (op_rd)
    );

    expr_pair_ram #(.AW(AW), .DW(2*W)) u_res_ram (
        .clk   (clk),
        .reset (reset),
        .we    (state == STORE),
        .wa    (idx),
        .wd    (res_wd),
        .ra    (rd_addr),
        .rd    (res_rd)
    );

    // Next-state and next-index decode
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (run) begin
                    state_n = count == '0 ? FIN : LOAD;
                    idx_n   = '0;
                end
            end
            LOAD:    state_n = dz ? STORE : cyc == CW'(LOAD_CYCLES - 1) ? CALC : LOAD;
            CALC:    state_n = cyc == CW'(CALC_CYCLES - 1) ? STORE : CALC;
            STORE: begin
                state_n = last ? FIN : LOAD;
                idx_n   = last ? idx : idx + AW'(1);
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, phase cycle counter, entry count and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            cyc   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cyc   <= (state_n == state && (state == LOAD || state == CALC)) ? cyc + CW'(1) : '0;
            if (accept)
                cnt <= count_sat;
            if (accept && count != '0)
                busy <= 1'b1;
            else if (state == FIN)
                busy <= 1'b0;
        end
    end

`ifdef DIVZERO_CHECK_EN
    // Zero-divisor flags, cleared at the start of every sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dz_flags <= '0;
        else if (accept)
            dz_flags <= '0;
        else if (state == STORE && dz)
            dz_flags[idx] <= 1'b1;
    end
`endif

endmodule

// File: doc/expr_div_sequencer.md
Name: expr_div_sequencer

Overview:
- Upstream driver and result collector for the sequential quotient/remainder divider stage.
- Holds a small operand memory of (x, y) pairs and, on a run command, issues each pair in turn to the divider.
- Drives the divider's load/calc protocol: load asserted for a fixed number of cycles, then released for a fixed compute window.
- Captures quot/rem into a result memory that the expression logic can read back.

Parameters:
- W, 16, operand/result width (matches the divider datapath)
- AW, 3, address width; DEPTH = 2**AW entries
- LOAD_CYCLES, 10, clk cycles div_load is held high per operand pair (min 1)
- CALC_CYCLES, 16, clk cycles div_load is held low before results are sampled (min 1)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write operand pair into memory
- wr_addr  in  AW  operand write address
- wr_x  in  W  dividend
- wr_y  in  W  divisor
- run  in  1  start sequence (level sampled in IDLE)
- count  in  AW+1  number of entries to process, from addr 0 (0..DEPTH)
- busy  out  1  high from run acceptance until done
- done  out  1  one-cycle pulse when the sequence completes
- rd_addr  in  AW  result read address
- rd_quot  out  W  registered quotient read data
- rd_rem  out  W  registered remainder read data
- div_x  out  W  divider dividend
- div_y  out  W  divider divisor
- div_load  out  1  divider load control (high = load)
- div_quot  in  W  divider quotient
- div_rem  in  W  divider remainder

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy=0, done=0, div_load=1.
  - div_x=0, div_y=0, rd_quot=0, rd_rem=0.
  - Index counter=0; memories are not cleared.
- Operand write: when wr_en=1 in IDLE, mem[wr_addr] <= {wr_x, wr_y} at the clock edge. Writes while busy=1 are ignored.
- Read: rd_quot/rd_rem <= res[rd_addr] with 1-cycle latency, legal in any state. A read of an entry written in the same cycle returns the old value.
- FSM states: IDLE, LOAD, CALC, STORE, FIN.
  - IDLE: if run=1 and count=0, go to FIN. If run=1 and count>0, set idx=0, latch cnt=count, busy<=1, go to LOAD.
  - LOAD:
    - div_x/div_y = mem[idx]; div_load=1.
    - Stay exactly LOAD_CYCLES cycles, then go to CALC.
    - div_x/div_y remain stable from LOAD through STORE.
  - CALC: div_load=0 for exactly CALC_CYCLES cycles, then go to STORE.
  - STORE:
    - res[idx] <= {div_quot, div_rem}, sampled in this cycle; div_load returns to 1.
    - If idx==cnt-1, go to FIN; else idx++ and go to LOAD.
  - FIN: done=1 for one cycle, busy<=0, go to IDLE.
- Latency per entry = LOAD_CYCLES + CALC_CYCLES + 1 cycles. Total = N·(L+C+1) + 1 cycles from run acceptance to done.
- run is ignored while busy. run held high in IDLE after FIN starts a new sequence on the next cycle.
- count > DEPTH saturates to DEPTH.
- idx does not wrap past cnt-1; the result memory beyond cnt-1 is untouched.
- Reset asserted mid-sequence aborts immediately to IDLE with the reset values above. Partial results already stored are retained.
- The divider sees div_load=1 whenever the block is idle, so the divider stays in load state between jobs.

Optional Feature:
- Macro: DIVZERO_CHECK_EN.
- With the macro defined, in LOAD, if mem[idx].y==0:
  - Skip LOAD/CALC: go straight to STORE on the next cycle.
  - Store quot = all-ones and rem = x.
  - Set bit idx of an added output port dz_flags[DEPTH-1:0]. dz_flags is cleared on run acceptance and on reset.
- Without the macro: no dz_flags port. A zero divisor is issued to the divider like any other pair and its outputs are stored unchanged.

Decomposition:
- Shared package expr_div_pkg holds:
  - the state enum (IDLE, LOAD, CALC, STORE, FIN);
  - the operand-pair and result-pair struct typedefs (W-wide fields);
  - default W/AW constants.
- One natural sub-module: expr_pair_ram, a DEPTH×2W synchronous-write RAM with registered read. It is instantiated twice: once for operands and once for results (the result read port is shared with the rd_* path).

Test Plan:
- Reset then write mem[0]=(6,2), run, count=1, with the real divider attached:
  - div_load high for 10 cycles with div_x=6, div_y=2, then low for 16 cycles;
  - done at cycle 28; read addr 0 returns quot=3, rem=0.
- Write (12,4), (17,5), (100,7) and run with count=3:
  - three LOAD/CALC/STORE passes; done once;
  - reads return (3,0), (3,2), (14,2).
- run with count=0 → done pulses on the next cycle; busy never rises; div_load stays 1.
- While busy, pulse wr_en to addr 0 with (9,9) and pulse run → operand and result unchanged; only one done pulse occurs.
- Assert reset during CALC of entry 1 of 3 → all outputs take reset values asynchronously. res[0] is retained; res[1] and res[2] are unchanged.
- With DIVZERO_CHECK_EN, write (5,0) at addr 0 and run with count=1:
  - no LOAD/CALC cycles; done at cycle 3;
  - result is quot=16'hFFFF, rem=5, and dz_flags[0]=1.
